fb_swap_ctrl: RTL and testbench

Double-buffer controller between the Nios processor system's pixel-write PIO exports and the dual-bank frame-buffer RAM. Turns the processor's software-driven write-enable and done levels into single-cycle RAM writes on the back bank. Performs the buffer swap at vertical blank and clears the new back bank. Reports readiness back to the processor on its swap input.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_clear_engine.sv | 48 ++++
 rtl/fb_swap_ctrl.sv | 152 +++++++++++++++
 tb/tb_fb_swap_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Frame-buffer swap controller shared types and defaults.
// Shared by the swap FSM and the bank clear engine.
package fb_pkg;

  localparam int ADDR_W_DEF     = 17;
  localparam int PIX_W_DEF      = 16;
  localparam int NUM_PIXELS_DEF = 76800;
  localparam int FRAME_CNT_W    = 16;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_DRAW    = 2'd1,
    ST_WAIT_VS = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_clear_engine.sv
// Back-bank clear address generator.
// Busy out of reset so the first bank is cleared without a start pulse.
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int NUM_PIXELS = NUM_PIXELS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  assign busy_o = busy_q;
  assign addr_o = cnt_q;
  assign last_o = busy_q && (cnt_q == ADDR_W'(NUM_PIXELS - 1));

  // Restart on start, otherwise step once per cycle until the last pixel.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (last_o) busy_d = 1'b0;
      else        cnt_d  = cnt_q + ADDR_W'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer controller: CPU pixel writes, vblank swap, bank clear.
// All outputs registered; writes always target the back bank.
module fb_swap_ctrl
  import fb_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                PIX_W       = PIX_W_DEF,
  parameter int                NUM_PIXELS  = NUM_PIXELS_DEF,
  parameter bit                CLEAR_EN    = 1'b1,
  parameter logic [PIX_W-1:0]  CLEAR_COLOR = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_we,
  input  logic [31:0]            cpu_waddr,
  input  logic [31:0]            cpu_din,
  input  logic                   cpu_done,
  input  logic                   vsync,
  output logic                   swap,
  output logic                   front_sel,
  output logic                   mem_we,
  output logic [ADDR_W:0]        mem_addr,
  output logic [PIX_W-1:0]       mem_wdata,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   err_drop,
  output logic                   err_oob
);

  fb_state_e               state_q, state_d;
  logic                    we_q, done_q;
  logic                    front_q, front_d;
  logic                    swap_q, swap_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_W:0]         mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]        mem_wdata_q, mem_wdata_d;
  logic [FRAME_CNT_W-1:0]  frame_q, frame_d;
  logic                    drop_q, drop_d;
  logic                    oob_q, oob_d;

  logic              we_rise, done_rise, in_rng;
  logic              clr_start, clr_busy, clr_last;
  logic [ADDR_W-1:0] clr_addr;
  logic              unused_ok;

  assign we_rise   = cpu_we & ~we_q;
  assign done_rise = cpu_done & ~done_q;
  assign in_rng    = cpu_waddr < 32'(NUM_PIXELS);
  assign unused_ok = ^{cpu_din[31:PIX_W], clr_last};

  fb_clear_engine #(
    .ADDR_W     (ADDR_W),
    .NUM_PIXELS (NUM_PIXELS)
  ) u_clr (
    .clk     (clk),
    .rst     (reset),
    .start_i (clr_start),
    .busy_o  (clr_busy),
    .last_o  (clr_last),
    .addr_o  (clr_addr)
  );

  // FSM, write mux and error flags.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    frame_d     = frame_q;
    drop_d      = drop_q;
    oob_d       = oob_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    clr_start   = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        if (we_rise) drop_d = 1'b1;
        if (clr_busy) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = {~front_q, clr_addr};
          mem_wdata_d = CLEAR_COLOR;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (we_rise) begin
          if (in_rng) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {~front_q, cpu_waddr[ADDR_W-1:0]};
            mem_wdata_d = cpu_din[PIX_W-1:0];
          end else begin
            oob_d = 1'b1;
          end
        end
        if (done_rise) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (we_rise) drop_d = 1'b1;
        if (vsync) begin
          front_d = ~front_q;
          frame_d = frame_q + FRAME_CNT_W'(1);
          if (CLEAR_EN) begin
            state_d   = ST_CLEAR;
            clr_start = 1'b1;
          end else begin
            state_d = ST_DRAW;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    swap_d = (state_d == ST_DRAW);
  end

  // State, edge-detect and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      front_q     <= 1'b0;
      swap_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      frame_q     <= '0;
      drop_q      <= 1'b0;
      oob_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= cpu_we;
      done_q      <= cpu_done;
      front_q     <= front_d;
      swap_q      <= swap_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      frame_q     <= frame_d;
      drop_q      <= drop_d;
      oob_q       <= oob_d;
    end
  end

  assign swap      = swap_q;
  assign front_sel = front_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign frame_cnt = frame_q;
  assign err_drop  = drop_q;
  assign err_oob   = oob_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl with a 16-pixel bank.
// Directed vector table plus clear/reset sequences.
module tb_fb_swap_ctrl;

  localparam int AW = 4;
  localparam int PW = 16;
  localparam int NP = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_waddr = '0;
  logic [31:0] cpu_din = '0;
  logic        cpu_done = 1'b0;
  logic        vsync = 1'b0;
  logic        swap, front_sel, mem_we, err_drop, err_oob;
  logic [AW:0]   mem_addr;
  logic [PW-1:0] mem_wdata;
  logic [15:0]   frame_cnt;

  fb_swap_ctrl #(
    .ADDR_W      (AW),
    .PIX_W       (PW),
    .NUM_PIXELS  (NP),
    .CLEAR_EN    (1'b1),
    .CLEAR_COLOR (16'h0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_waddr (cpu_waddr),
    .cpu_din   (cpu_din),
    .cpu_done  (cpu_done),
    .vsync     (vsync),
    .swap      (swap),
    .front_sel (front_sel),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .frame_cnt (frame_cnt),
    .err_drop  (err_drop),
    .err_oob   (err_oob)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] din;
    logic        done;
    logic        vs;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [15:0] e_data;
    logic        e_swap;
    logic        e_front;
    logic [15:0] e_frame;
    logic        e_drop;
    logic        e_oob;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic we, input logic [31:0] wa,
                     input logic [31:0] din, input logic done,
                     input logic vs, input logic e_we,
                     input logic [4:0] ea, input logic [15:0] ed,
                     input logic es, input logic ef,
                     input logic [15:0] efr, input logic edr,
                     input logic eo);
    vec_t v;
    v.we = we; v.wa = wa; v.din = din; v.done = done; v.vs = vs;
    v.e_we = e_we; v.e_addr = ea; v.e_data = ed; v.e_swap = es;
    v.e_front = ef; v.e_frame = efr; v.e_drop = edr; v.e_oob = eo;
    vq.push_back(v);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " swap"}, swap, 0);
    chk({nm, " front"}, front_sel, 0);
    chk({nm, " mem_we"}, mem_we, 0);
    chk({nm, " addr"}, mem_addr, 0);
    chk({nm, " data"}, mem_wdata, 0);
    chk({nm, " frame"}, frame_cnt, 0);
    chk({nm, " drop"}, err_drop, 0);
    chk({nm, " oob"}, err_oob, 0);
  endtask

  task automatic collect_clear(input logic [4:0] base, input int vs_at,
                               input string nm);
    int  n;
    bit  fin;
    n = 0;
    fin = 1'b0;
    for (int t = 1; t <= 40 && !fin; t++) begin
      vsync = (t == vs_at);
      tick();
      vsync = 1'b0;
      if (mem_we) begin
        chk({nm, " addr"}, mem_addr, 32'(base) + n);
        chk({nm, " data"}, mem_wdata, 0);
        chk({nm, " tick"}, t, n + 1);
        n++;
      end
      if (swap) begin
        fin = 1'b1;
        chk({nm, " writes"}, n, NP);
        chk({nm, " swap tick"}, t, NP + 1);
      end
    end
    if (!fin) chk({nm, " timeout"}, 0, 1);
  endtask

  initial begin
    bit hit;

    #2;
    chk_reset_vals("rst");
    tick();
    tick();
    reset = 1'b0;
    collect_clear(5'h10, 0, "clr0");

    add(1, 5, 16'hABCD, 0, 0, 1, 5'h15, 16'hABCD, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 3, 16'h1111, 0, 0, 1, 5'h13, 16'h1111, 1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++)
      add(1, 3, 16'h1111, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(1, 16, 16'h2222, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 32'h8000_0005, 16'h3333, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 15, 16'h0F0F, 0, 0, 1, 5'h1F, 16'h0F0F, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(1, 2, 16'hBEEF, 1, 0, 1, 5'h12, 16'hBEEF, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 7, 16'h4444, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 1);

    foreach (vq[i]) begin
      cpu_we = vq[i].we;
      cpu_waddr = vq[i].wa;
      cpu_din = vq[i].din;
      cpu_done = vq[i].done;
      vsync = vq[i].vs;
      tick();
      chk($sformatf("v%0d mem_we", i), mem_we, vq[i].e_we);
      if (vq[i].e_we) begin
        chk($sformatf("v%0d addr", i), mem_addr, vq[i].e_addr);
        chk($sformatf("v%0d data", i), mem_wdata, vq[i].e_data);
      end
      chk($sformatf("v%0d swap", i), swap, vq[i].e_swap);
      chk($sformatf("v%0d front", i), front_sel, vq[i].e_front);
      chk($sformatf("v%0d frame", i), frame_cnt, vq[i].e_frame);
      chk($sformatf("v%0d drop", i), err_drop, vq[i].e_drop);
      chk($sformatf("v%0d oob", i), err_oob, vq[i].e_oob);
    end
    cpu_we = 0;
    cpu_done = 0;
    vsync = 0;

    collect_clear(5'h00, 6, "clr1");
    chk("clr1 front", front_sel, 1);
    chk("clr1 frame", frame_cnt, 1);

    cpu_we = 1; cpu_waddr = 5; cpu_din = 16'h1234;
    tick();
    cpu_we = 0;
    chk("b0 mem_we", mem_we, 1);
    chk("b0 addr", mem_addr, 5'h05);
    chk("b0 data", mem_wdata, 16'h1234);

    cpu_done = 1;
    tick();
    cpu_done = 0;
    chk("f2 swap", swap, 0);
    vsync = 1;
    tick();
    vsync = 0;
    chk("f2 front", front_sel, 0);
    chk("f2 frame", frame_cnt, 2);

    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      if (mem_we && mem_addr == 5'h17) hit = 1'b1;
    end
    chk("midclr reach", hit, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    reset = 1'b0;
    collect_clear(5'h10, 0, "clr2");
    chk("clr2 front", front_sel, 0);
    chk("clr2 frame", frame_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
